// File: rtl/rvm_mem_ctrl.sv
// Memory-side controller: core request/stall port to a 1-cycle-latency single-port SRAM, with wait states and fault checks.
// Define RVM_MEM_CTRL_ERR_CAPTURE_EN to add a sticky first-fault address capture (err_clr/err_valid/err_addr).
module rvm_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = $clog2(DEPTH_WORDS),
  parameter int          WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic          mem_c_en,
  input  logic [3:0]    mem_b_en,
  input  logic          mem_w_en,
  output logic [31:0]   mem_rdata,
  output logic          mem_error,
  output logic          mem_stall,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
`ifdef RVM_MEM_CTRL_ERR_CAPTURE_EN
  input  logic          err_clr,
  output logic          err_valid,
  output logic [31:0]   err_addr,
`endif
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic [AW-1:0]   lat_idx;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;
  logic            lat_we;
  logic            lat_fault;

  logic [31:0]     offset;
  logic            range_fault;
  logic            lane_ok;
  logic [1:0]      lsb_idx;
  logic            req_fault;
  logic            accept;

  // Request legality: address window, byte-lane pattern, and lane/address alignment.
  assign offset      = mem_addr - BASE_ADDR;
  assign range_fault = {1'b0, offset} >= LIMIT;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lane_ok = 1'b0;
    lsb_idx = 2'd0;
    case (mem_b_en)
      4'b0001, 4'b0011, 4'b1111: begin lane_ok = 1'b1; lsb_idx = 2'd0; end
      4'b0010:                   begin lane_ok = 1'b1; lsb_idx = 2'd1; end
      4'b0100, 4'b1100:          begin lane_ok = 1'b1; lsb_idx = 2'd2; end
      4'b1000:                   begin lane_ok = 1'b1; lsb_idx = 2'd3; end
      default:                   begin lane_ok = 1'b0; lsb_idx = 2'd0; end
    endcase
  end

  assign req_fault = range_fault | ~lane_ok | (mem_addr[1:0] != lsb_idx);
  assign accept    = (state == S_IDLE) && mem_c_en;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (mem_c_en) state_next = req_fault ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_we    <= 1'b0;
      lat_fault <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt       <= 4'(WAIT_STATES);
        lat_idx   <= offset[AW+1:2];
        lat_wdata <= mem_wdata;
        lat_be    <= mem_b_en;
        lat_we    <= mem_w_en;
        lat_fault <= req_fault;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // SRAM strobe is a decode of registered state, so reset removes it asynchronously.
  assign sram_cs    = (state == S_WAIT) && (cnt == 4'd0);
  assign sram_we    = sram_cs & lat_we;
  assign sram_be    = sram_cs ? lat_be    : 4'd0;
  assign sram_addr  = sram_cs ? lat_idx   : '0;
  assign sram_wdata = sram_cs ? lat_wdata : 32'd0;

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      S_IDLE:  mem_stall = mem_c_en & resetn;
      S_WAIT:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  assign mem_error = (state == S_RESP) & lat_fault;
  assign mem_rdata = ((state == S_RESP) && !lat_fault && !lat_we) ? sram_rdata : 32'd0;

`ifdef RVM_MEM_CTRL_ERR_CAPTURE_EN
  logic capture;

  // A new fault beats a simultaneous clear, and an armed capture keeps the first address.
  assign capture = accept && req_fault && (!err_valid || err_clr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_valid <= 1'b0;
      err_addr  <= 32'd0;
    end else if (capture) begin
      err_valid <= 1'b1;
      err_addr  <= mem_addr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr  <= 32'd0;
    end
  end
`endif

endmodule
